// File: rtl/apb_master_port.sv
// Single-outstanding APB initiator: turns a valid/ready command stream into APB
// setup/access phases, honours PREADY wait states and aborts on a programmable timeout.
module apb_master_port #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  // host command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // host response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  // APB
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  // A zero TIMEOUT still gets a 1-bit counter so the declaration stays legal.
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a ready on the final allowed cycle succeeds.
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    // NOTE: the async reset clears every flop, including the data holding
    // registers, so an in-flight transfer leaves no stale response behind.
    if (!PRESETN) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: doc/apb_master_port.md
# apb_master_port

Single-outstanding APB initiator that issues 8-bit read/write transfers to the UART APB core's 2-bit register space. It converts a valid/ready command stream into APB setup/access phases, inserts wait states on PREADY, and aborts on a programmable timeout. It returns read data and a timeout flag on a valid/ready response port. It sits between a host-side controller (CPU shim, test sequencer) and the UART core's APB slave port.

## Interface
- DATA_W, 8: PWDATA/PRDATA/command/response data width
- ADDR_W, 2: PADDR width
- TIMEOUT, 16: ACCESS-phase cycles allowed without PREADY before abort; 0 disables the timeout
- PCLK  in  1  single clock; all logic on rising edge
- PRESETN  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register
- cmd_wdata  in  DATA_W  write data (ignored on reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_W  captured PRDATA (reads), 0 for writes and timeouts
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready / wait-state control

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, register cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, clear timeout counter, go SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Sample PREADY each cycle.
  - PREADY=1: transfer completes. Capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_timeout=0, go RESP.
  - PREADY=0 and TIMEOUT≠0 and counter = TIMEOUT-1: abort. rsp_rdata=0, rsp_timeout=1, go RESP.
  - Otherwise, increment counter and stay.
  - PREADY=1 on the timeout cycle counts as success (PREADY wins).
- RESP: PSEL=PENABLE=0, rsp_valid=1. rsp_rdata/rsp_timeout are held stable. On rsp_ready, go IDLE.
- Counter is $clog2(TIMEOUT+1) bits and saturates. It is never compared when TIMEOUT=0, so ACCESS waits indefinitely.
- PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS. Outside a transfer they hold their last value.
- Exactly one transfer outstanding. A new command is not accepted until the response is consumed.
- Reset (async, any state): state=IDLE, PSEL=PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, counter=0. cmd_ready reads 1 (IDLE). An in-flight transfer is dropped with no response.

## Timing
- All outputs are registered except cmd_ready, which decodes state==IDLE.
- Command accepted at edge N → SETUP during cycle N..N+1 → ACCESS from edge N+1.
- PREADY high in first ACCESS cycle → rsp_valid high after edge N+2. Minimum command-to-response latency is 3 cycles.
- Each PREADY=0 ACCESS cycle adds 1 cycle.
- Timeout: with TIMEOUT=T, ACCESS lasts exactly T cycles, and rsp_valid rises on the following edge.
- rsp_ready held high: RESP lasts 1 cycle, IDLE lasts 1 cycle. Maximum throughput is 1 transfer per 4 cycles with zero wait states.
- PSEL never glitches between SETUP and ACCESS. PENABLE is high only in ACCESS.

## Test plan
- Write, zero wait: cmd write addr=2'b01 data=8'hA5, PREADY=1 → SETUP 1 cycle then ACCESS 1 cycle with PADDR=1, PWRITE=1, PWDATA=A5. rsp_valid 3 cycles after accept, rsp_rdata=00, rsp_timeout=0.
- Read with waits: cmd read addr=2'b00, PREADY low 3 ACCESS cycles, PRDATA=8'h3C on 4th → ACCESS lasts 4 cycles, rsp_rdata=3C, latency 6 cycles.
- Timeout: TIMEOUT=16, PREADY stuck 0 → ACCESS exactly 16 cycles, then PSEL=0, rsp_timeout=1, rsp_rdata=00. With TIMEOUT=0 and 100 stall cycles → still in ACCESS. Then PREADY=1 completes normally.
- Boundary: PREADY rises on the 16th ACCESS cycle (TIMEOUT=16) → success, rsp_timeout=0.
- Backpressure: rsp_ready low 5 cycles, cmd_valid held high with a second command → cmd_ready=0 and rsp fields stable for all 5 cycles. The second command is accepted only after the rsp handshake and IDLE.
- Reset mid-ACCESS: drop PRESETN during a stalled read → PSEL/PENABLE/rsp_valid go 0 immediately without a clock. After release, cmd_ready=1 and a fresh write completes normally.
